sid_slot_sched: RTL
===================

Name: sid_slot_sched

Overview:
- Time-slot scheduler that shares one waveform-table lookup unit and one filter datapath among up to 4 SID chip instances.
- On every 1 MHz tick it sequences table lookups for every voice of every enabled chip, then runs the filter once per enabled chip.
- It emits select indices, request/capture strobes and filter state to the shared resources, and flags tick overruns.
- It sits between the SID register/voice instances and the shared table/filter blocks.

Parameters:
- CHIPS, 2, number of SID instances served (legal 1..4).
- TBL_LAT, 2, clocks from table request to valid table output (legal 1..7).
- FLT_CYC, 8, filter clocks per chip (legal 2..16).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce_1m  in  1  1 MHz tick, one clk wide; starts a sequence.
- chip_en  in  CHIPS  per-chip enable, sampled only on the ce_1m cycle.
- tbl_req  out  1  table lookup request strobe.
- tbl_chip  out  2  chip index for tbl_req.
- tbl_voice  out  2  voice index 0..2 for tbl_req.
- tbl_cap  out  1  table result valid; consumer latches it into (cap_chip, cap_voice).
- cap_chip  out  2  chip index for tbl_cap.
- cap_voice  out  2  voice index for tbl_cap.
- flt_active  out  1  filter phase running.
- flt_start  out  1  first filter clock of a chip.
- flt_state  out  4  filter step 0..FLT_CYC-1.
- flt_chip  out  2  chip currently owning the filter (drives its register and mode mux).
- audio_cap  out  1  latch filter output for flt_chip.
- busy  out  1  sequence in progress.
- done  out  1  one-clk pulse at sequence end.
- overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - overrun is cleared only by reset.
  - Reset mid-sequence abandons it immediately, with no done pulse.
- Timing reference:
  - Cycle 0 is the clk on which ce_1m=1.
  - chip_en is latched there as en_q, and E = popcount(en_q).
- FSM states: IDLE, TBL, FLT, FIN.
- Ordering:
  - Slots run over enabled chips in ascending index.
  - Within each chip, voices run 0,1,2.
  - Slot k = 0..3E-1.
- TBL phase:
  - Entered at cycle 1.
  - tbl_req is pulsed at cycle 1+2k, with tbl_chip/tbl_voice for slot k.
  - Indices are valid only while tbl_req=1 and are 0 otherwise.
- Capture:
  - tbl_cap is pulsed at cycle 1+2k+TBL_LAT, with cap_chip/cap_voice equal to slot k's indices.
  - A delay line of depth TBL_LAT carries the indices.
  - Request and capture pulses may share a cycle; each uses its own index ports.
- TBL to FLT:
  - TBL ends after the last capture (cycle 6E-1+TBL_LAT).
  - FLT begins at cycle 6E+TBL_LAT.
- FLT phase:
  - Each enabled chip owns FLT_CYC consecutive clocks.
  - flt_state counts 0..FLT_CYC-1.
  - flt_start=1 when flt_state=0.
  - audio_cap=1 when flt_state=FLT_CYC-1.
  - flt_active=1 throughout FLT.
  - flt_chip and flt_state are 0 outside FLT.
- FIN: at cycle 6E+TBL_LAT+FLT_CYC*E, done=1 for one clk, busy=0, and the FSM returns to IDLE.
- busy is 1 from cycle 1 through the last FLT clock.
- E=0: no req, cap or filter activity; done pulses at cycle 1 and busy stays 0.
- ce_1m while busy (including on the done cycle):
  - overrun is set.
  - The in-flight sequence is aborted, including pending captures: the delay line is flushed and no tbl_cap fires for aborted slots.
  - A new sequence restarts with that cycle as cycle 0.
- chip_en changes outside the ce_1m cycle have no effect until the next tick.
- Counters saturate at their terminal counts; there is no wrap within a sequence.

Test Plan:
- Defaults, chip_en=2'b11, single ce_1m:
  - tbl_req at cycles 1,3,5,7,9,11 with (chip,voice)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - tbl_cap at 3..13 odd with matching indices.
  - flt_start at 14 (chip 0) and 22 (chip 1); audio_cap at 21 and 29.
  - done at 30; overrun stays 0.
- chip_en=2'b10: only chip 1 is served.
  - Reqs at 1,3,5; caps at 3,5,7.
  - flt_start at 8 (flt_chip=1), audio_cap at 15, done at 16.
- chip_en=0: done pulse at cycle 1; no tbl_req, tbl_cap or flt_active; busy never 1.
- Defaults, both chips enabled, second ce_1m at cycle 10:
  - overrun=1 from cycle 11.
  - No tbl_cap for the aborted slot k=4 (due at 11).
  - Restart: tbl_req at 11 with (0,0); done at 40.
- reset asserted at cycle 16 of a full sequence:
  - All outputs 0 from the next cycle; no done pulse.
  - A following ce_1m runs a clean full sequence.
- CHIPS=4, TBL_LAT=3, FLT_CYC=16, chip_en=4'b1111:
  - Last req at 23 with (3,2); last cap at 26.
  - flt_start at 27,43,59,75; done at 91.

Source files
------------

// File: rtl/sid_slot_sched.sv
`default_nettype none
// ============================================================================
// sid_slot_sched : per-tick slot scheduler sharing one table unit and one filter
//                  datapath across up to four SID instances.   rev 1.0
// ============================================================================
module sid_slot_sched #(
  parameter int CHIPS   = 2,
  parameter int TBL_LAT = 2,
  parameter int FLT_CYC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_1m,
  input  logic [CHIPS-1:0] chip_en,
  output logic             tbl_req,
  output logic [1:0]       tbl_chip,
  output logic [1:0]       tbl_voice,
  output logic             tbl_cap,
  output logic [1:0]       cap_chip,
  output logic [1:0]       cap_voice,
  output logic             flt_active,
  output logic             flt_start,
  output logic [3:0]       flt_state,
  output logic [1:0]       flt_chip,
  output logic             audio_cap,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TBL  = 2'd1;
  localparam logic [1:0] S_FLT  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;
  localparam logic [3:0] FLT_LAST = 4'(FLT_CYC - 1);

  logic [1:0]         state_q, state_d;
  logic [CHIPS-1:0]   en_q, en_d;
  logic [CHIPS-1:0]   rem_q, rem_d;
  logic [1:0]         voice_q, voice_d;
  logic               ph_q, ph_d;
  logic [3:0]         fstate_q, fstate_d;
  logic               overrun_q, overrun_d;
  logic [TBL_LAT-1:0]      pv_q, pv_d;
  logic [TBL_LAT-1:0][1:0] pc_q, pc_d;
  logic [TBL_LAT-1:0][1:0] pw_q, pw_d;

  logic             req;
  logic [1:0]       req_chip;
  logic [1:0]       req_voice;
  logic [1:0]       cur_chip;
  logic [CHIPS-1:0] rem_next;
  logic             pend;

  // Lowest set bit of the remaining mask is the chip currently being served.
  function automatic logic [1:0] lowest(input logic [CHIPS-1:0] m);
    lowest = 2'd0;
    for (int i = CHIPS - 1; i >= 0; i--) begin
      if (m[i]) lowest = i[1:0];
    end
  endfunction

  assign cur_chip  = lowest(rem_q);
  assign rem_next  = rem_q & (rem_q - CHIPS'(1));
  assign req       = (state_q == S_TBL) && !ph_q && (rem_q != '0);
  assign req_chip  = req ? cur_chip : 2'd0;
  assign req_voice = req ? voice_q : 2'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      en_q      <= '0;
      rem_q     <= '0;
      voice_q   <= 2'd0;
      ph_q      <= 1'b0;
      fstate_q  <= 4'd0;
      overrun_q <= 1'b0;
      pv_q      <= '0;
      pc_q      <= '0;
      pw_q      <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      rem_q     <= rem_d;
      voice_q   <= voice_d;
      ph_q      <= ph_d;
      fstate_q  <= fstate_d;
      overrun_q <= overrun_d;
      pv_q      <= pv_d;
      pc_q      <= pc_d;
      pw_q      <= pw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    rem_d     = rem_q;
    voice_d   = voice_q;
    ph_d      = ph_q;
    fstate_d  = fstate_q;
    overrun_d = overrun_q;
    pv_d      = '0;
    pc_d      = '0;
    pw_d      = '0;
    pend      = 1'b0;

    pv_d[0] = req;
    pc_d[0] = req_chip;
    pw_d[0] = req_voice;
    for (int i = 1; i < TBL_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pc_d[i] = pc_q[i-1];
      pw_d[i] = pw_q[i-1];
    end
    // Captures still queued behind the one at the head of the delay line.
    for (int i = 0; i < TBL_LAT - 1; i++) begin
      pend = pend | pv_q[i];
    end

    case (state_q)
      S_TBL: begin
        ph_d = ~ph_q;
        if (req) begin
          if (voice_q == 2'd2) begin
            voice_d = 2'd0;
            rem_d   = rem_next;
          end else begin
            voice_d = voice_q + 2'd1;
          end
        end
        if (pv_q[TBL_LAT-1] && (rem_q == '0) && !pend) begin
          state_d  = S_FLT;
          rem_d    = en_q;
          fstate_d = 4'd0;
        end
      end
      S_FLT: begin
        if (fstate_q == FLT_LAST) begin
          fstate_d = 4'd0;
          rem_d    = rem_next;
          if (rem_next == '0) state_d = S_FIN;
        end else begin
          fstate_d = fstate_q + 4'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A tick always (re)starts a sequence, discarding anything in flight.
    if (ce_1m) begin
      overrun_d = overrun_q | (state_q != S_IDLE);
      en_d      = chip_en;
      rem_d     = chip_en;
      voice_d   = 2'd0;
      ph_d      = 1'b0;
      fstate_d  = 4'd0;
      pv_d      = '0;
      pc_d      = '0;
      pw_d      = '0;
      state_d   = (chip_en != '0) ? S_TBL : S_FIN;
    end
  end

  always_comb begin
    tbl_req    = req;
    tbl_chip   = req_chip;
    tbl_voice  = req_voice;
    tbl_cap    = pv_q[TBL_LAT-1];
    cap_chip   = pc_q[TBL_LAT-1];
    cap_voice  = pw_q[TBL_LAT-1];
    flt_active = (state_q == S_FLT);
    flt_state  = flt_active ? fstate_q : 4'd0;
    flt_chip   = flt_active ? cur_chip : 2'd0;
    flt_start  = flt_active && (fstate_q == 4'd0);
    audio_cap  = flt_active && (fstate_q == FLT_LAST);
    busy       = (state_q == S_TBL) || (state_q == S_FLT);
    done       = (state_q == S_FIN);
    overrun    = overrun_q;
  end

endmodule
`default_nettype wire
